chan_array_block: RTL and testbench

- Parametrised multi-instance successor to the fixed two-instance shared-clock block.
- Instantiates NUM_CH identical chan_cell channels on one shared clk. Each channel counts event pulses.
- A round-robin readout stage drains the channel counts into one registered valid/ready output stream.
- Used as the per-channel event aggregator under the top-level block, and as an interface-registry test target with a configurable instance count.

---
 rtl/chan_array_pkg.sv | 24 ++
 rtl/chan_cell.sv | 63 ++++++
 rtl/chan_array_block.sv | 174 +++++++++++++++++
 tb/tb_chan_array_block.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_array_pkg.sv
// chan_array_pkg
//   Shared definitions for chan_array_block and chan_cell:
//   - calc_ch_w    : width of a channel index, never less than one bit
//   - rr_reset_ptr : round-robin pointer reset value, chosen so that channel 0
//                    is the first channel considered after reset
//   - flush_st_e   : state of the flush sequencer
package chan_array_pkg;

    function automatic int unsigned calc_ch_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // The grant search starts one past the pointer, so resetting it to the
    // last channel makes channel 0 the first candidate.
    function automatic int unsigned rr_reset_ptr(input int unsigned num_ch);
        return num_ch - 1;
    endfunction

    typedef enum logic [0:0] {
        FlushIdle,
        FlushPend
    } flush_st_e;

endpackage

// File: rtl/chan_cell.sv
// chan_cell
//   One event counter channel with saturation and threshold request.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     event_i    : one-cycle event pulse
//     en_i       : count enable; when low, events are ignored
//     clr_i      : readout of this channel happens at this edge
//     cnt_o      : registered count
//     sat_o      : an event arrived while the count was all-ones (sticky)
//     req_thr_o  : registered count has reached THRESH
module chan_cell #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned THRESH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             event_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o,
    output logic             req_thr_o
);

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] ThreshC = CNT_W'(THRESH);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             inc;

    always_comb begin
        inc   = event_i & en_i;
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr_i) begin
            // An event coinciding with readout starts the next count at 1.
            cnt_d = inc ? CNT_W'(1) : '0;
            sat_d = 1'b0;
        end else if (inc) begin
            if (cnt_q == CntMax) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign sat_o     = sat_q;
    assign req_thr_o = (cnt_q >= ThreshC);

endmodule

// File: rtl/chan_array_block.sv
// chan_array_block
//   NUM_CH event-counting channels on one clock, drained by a round-robin
//   arbiter into a registered valid/ready readout stream.
//   Ports:
//     clk, rst       : shared clock, asynchronous active-high reset
//     ch_event_i     : per-channel event pulse
//     ch_en_i        : per-channel count enable
//     flush_i        : pulse; drains every nonzero channel
//     out_valid_o    : readout entry valid
//     out_ready_i    : consumer accepts the entry
//     out_ch_o       : channel index of the entry
//     out_count_o    : count snapshot
//     out_sat_o      : channel saturated since its last readout
//     flush_done_o   : one-cycle pulse when a flush completes
module chan_array_block
    import chan_array_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned THRESH = 16,
    localparam int unsigned CH_W  = calc_ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_event_i,
    input  logic [NUM_CH-1:0] ch_en_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CH_W-1:0]   out_ch_o,
    output logic [CNT_W-1:0]  out_count_o,
    output logic              out_sat_o,
    output logic              flush_done_o
);

    localparam logic [CH_W-1:0] RR_RESET_PTR = CH_W'(rr_reset_ptr(NUM_CH));

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [CNT_W-1:0] count;
        logic             sat;
    } rd_entry_t;

    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] sat;
    logic [NUM_CH-1:0] req_thr;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] clr;

    logic              all_zero;
    logic              flush_pend;
    logic              load;
    logic              grant_found;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   cand;

    rd_entry_t         entry_q, entry_d;
    logic              out_valid_q;
    logic [CH_W-1:0]   rr_ptr_q;
    flush_st_e         flush_st_q;
    logic              flush_done_q;

    // Channels
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        chan_cell #(
            .CNT_W  (CNT_W),
            .THRESH (THRESH)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .event_i   (ch_event_i[i]),
            .en_i      (ch_en_i[i]),
            .clr_i     (clr[i]),
            .cnt_o     (cnt[i]),
            .sat_o     (sat[i]),
            .req_thr_o (req_thr[i])
        );
    end

    assign flush_pend = (flush_st_q == FlushPend);

    // Requests and the all-zero condition, both from registered counts.
    always_comb begin
        req      = '0;
        all_zero = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            req[i] = req_thr[i] | (flush_pend & (cnt[i] != '0));
            if (cnt[i] != '0) begin
                all_zero = 1'b0;
            end
        end
    end

    // Round-robin grant: first requester after rr_ptr_q, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((32'(rr_ptr_q) + k) % NUM_CH);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign load = (!out_valid_q || out_ready_i) && grant_found;

    always_comb begin
        clr = '0;
        if (load) begin
            clr[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        entry_d = entry_q;
        if (load) begin
            entry_d.ch    = grant_idx;
            entry_d.count = cnt[grant_idx];
            entry_d.sat   = sat[grant_idx];
        end
    end

    // Output register and arbitration pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q     <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= RR_RESET_PTR;
        end else begin
            entry_q <= entry_d;
            if (load) begin
                out_valid_q <= 1'b1;
                rr_ptr_q    <= grant_idx;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Flush sequencer. A flush seen while already pending is absorbed;
    // completion waits for all counts to be zero with no load in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_st_q   <= FlushIdle;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            unique case (flush_st_q)
                FlushIdle: begin
                    if (flush_i) begin
                        flush_st_q <= FlushPend;
                    end
                end
                FlushPend: begin
                    if (all_zero && !load) begin
                        flush_st_q   <= FlushIdle;
                        flush_done_q <= 1'b1;
                    end
                end
                default: flush_st_q <= FlushIdle;
            endcase
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_ch_o     = entry_q.ch;
    assign out_count_o  = entry_q.count;
    assign out_sat_o    = entry_q.sat;
    assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_chan_array_block.sv
// Randomized scoreboard bench for chan_array_block with a queue-based
// reference model of the channel counters, arbiter and flush behaviour.
module tb_chan_array_block;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned THRESH = 5;
    localparam int unsigned CH_W   = 2;
    localparam int          CMAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] ev;
    logic [NUM_CH-1:0] en;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   out_ch;
    logic [CNT_W-1:0]  out_count;
    logic              out_sat;
    logic              flush_done;

    int checks = 0;
    int errors = 0;

    chan_array_block #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .THRESH (THRESH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ch_event_i   (ev),
        .ch_en_i      (en),
        .flush_i      (flush),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_ch_o     (out_ch),
        .out_count_o  (out_count),
        .out_sat_o    (out_sat),
        .flush_done_o (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        int ch;
        int count;
        bit sat;
    } ent_t;

    ent_t exp_q[$];
    int   m_cnt[NUM_CH];
    bit   m_sat[NUM_CH];
    int   m_last;
    bit   m_pend;
    bit   m_valid;
    bit   m_done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0;
            m_sat[i] = 0;
        end
        m_last  = NUM_CH - 1;
        m_pend  = 0;
        m_valid = 0;
        m_done  = 0;
        exp_q.delete();
    endtask

    // One clock edge of the reference behaviour, using the inputs as driven.
    task automatic model_step();
        int  g;
        int  c;
        bit  load;
        bit  allz;
        ent_t e;
        g    = -1;
        allz = 1;
        for (int k = 1; k <= NUM_CH; k++) begin
            c = (m_last + k) % NUM_CH;
            if (g < 0 && (m_cnt[c] >= THRESH || (m_pend && m_cnt[c] != 0))) g = c;
        end
        for (int i = 0; i < NUM_CH; i++) if (m_cnt[i] != 0) allz = 0;
        load = (g >= 0) && (!m_valid || out_ready);
        if (load) begin
            e.ch    = g;
            e.count = m_cnt[g];
            e.sat   = m_sat[g];
            exp_q.push_back(e);
            m_last = g;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            bit inc;
            inc = ev[i] && en[i];
            if (load && i == g) begin
                m_cnt[i] = inc ? 1 : 0;
                m_sat[i] = 0;
            end else if (inc) begin
                if (m_cnt[i] == CMAX) m_sat[i] = 1;
                else m_cnt[i] = m_cnt[i] + 1;
            end
        end
        if (load) m_valid = 1;
        else if (out_ready) m_valid = 0;
        if (m_pend && allz && !load) begin
            m_pend = 0;
            m_done = 1;
        end else begin
            m_done = 0;
            if (flush) m_pend = 1;
        end
    endtask

    task automatic tick_set(input logic [NUM_CH-1:0] e, input logic [NUM_CH-1:0] n,
                            input logic r, input logic f);
        @(posedge clk);
        if (!rst) model_step();
        #1;
        ev        = e;
        en        = n;
        out_ready = r;
        flush     = f;
    endtask

    task automatic tick_rand(input int p_ev, input int p_en, input int p_rdy, input int p_fl);
        logic [NUM_CH-1:0] e;
        logic [NUM_CH-1:0] n;
        for (int i = 0; i < NUM_CH; i++) begin
            e[i] = ($urandom_range(99) < p_ev);
            n[i] = ($urandom_range(99) < p_en);
        end
        tick_set(e, n, ($urandom_range(99) < p_rdy), ($urandom_range(99) < p_fl));
    endtask

    // Monitor: compares the presented stream against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("out_valid", int'(out_valid), int'(m_valid));
                chk("flush_done", int'(flush_done), int'(m_done));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("entry_expected", 0, 1);
                    end else begin
                        chk("out_ch", int'(out_ch), exp_q[0].ch);
                        chk("out_count", int'(out_count), exp_q[0].count);
                        chk("out_sat", int'(out_sat), int'(exp_q[0].sat));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    localparam logic [NUM_CH-1:0] All  = '1;
    localparam logic [NUM_CH-1:0] None = '0;
    localparam logic [NUM_CH-1:0] Ch0  = 1;
    localparam logic [NUM_CH-1:0] Ch1  = 2;

    initial begin
        int guard;
        rst       = 1'b1;
        ev        = '0;
        en        = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #3;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_ch", int'(out_ch), 0);
        chk("reset_out_count", int'(out_count), 0);
        chk("reset_out_sat", int'(out_sat), 0);
        chk("reset_flush_done", int'(flush_done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Threshold readout on channel 0
        repeat (THRESH) tick_set(Ch0, All, 1'b1, 1'b0);
        repeat (4) tick_set(None, All, 1'b1, 1'b0);

        // Simultaneous events on all channels: round robin order
        repeat (12) tick_set(All, All, 1'b1, 1'b0);
        repeat (6) tick_set(None, All, 1'b1, 1'b0);

        // Saturation and long backpressure hold, disabled channel 2
        repeat (20) tick_set(Ch1 | Ch0, 3'b011, 1'b0, 1'b0);
        tick_set(Ch0, All, 1'b1, 1'b0);
        repeat (8) tick_set(None, All, 1'b1, 1'b0);

        // Flush of small counts, then flush with everything already zero
        repeat (2) tick_set(Ch0, All, 1'b1, 1'b0);
        tick_set(Ch1, All, 1'b1, 1'b0);
        tick_set(None, All, 1'b1, 1'b1);
        repeat (8) tick_set(None, All, 1'b1, 1'b0);
        tick_set(None, All, 1'b1, 1'b1);
        repeat (5) tick_set(None, All, 1'b1, 1'b0);

        // Random traffic
        repeat (300) tick_rand(60, 90, 70, 3);

        // Asynchronous reset while an entry is held
        repeat (12) tick_set(All, All, 1'b0, 1'b0);
        @(posedge clk);
        model_step();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_out_count", int'(out_count), 0);
        chk("async_rst_out_sat", int'(out_sat), 0);
        chk("async_rst_out_ch", int'(out_ch), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ev  = All;
        en  = All;
        out_ready = 1'b1;
        flush = 1'b0;
        repeat (10) tick_set(All, All, 1'b1, 1'b0);

        // More random traffic with heavier flush and backpressure
        repeat (400) tick_rand(50, 85, 50, 8);

        // Drain everything, bounded
        tick_set(None, All, 1'b1, 1'b1);
        guard = 0;
        while ((exp_q.size() != 0 || m_valid || m_pend) && guard < 60) begin
            tick_set(None, All, 1'b1, 1'b0);
            guard++;
        end
        repeat (3) tick_set(None, All, 1'b1, 1'b0);
        chk("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
